// File: rtl/i2c_pkg.sv
// Shared I2C constants, scheduler state encoding and width helpers used by the
// bus scheduler, the byte master and the display driver.
package i2c_pkg;

  localparam int NREQ_DEF    = 3;
  localparam int MAXB_DEF    = 4;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } sched_state_e;

  // Width able to hold a byte count of 0..maxb.
  function automatic int len_w(input int maxb);
    return $clog2(maxb + 1);
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr_i wins.
// Holds no state; the pointer lives in the scheduler.
module i2c_rr_pick
  import i2c_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PTR_W = $clog2(NREQ_DEF)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  win_o,
  output logic             any_o
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest offset back to ptr_i so the closest hit is written last.
  always_comb begin
    win_o = '0;
    cand  = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = PTR_W'((int'(ptr_i) + off) % NREQ);
      if (req_i[cand]) begin
        win_o       = '0;
        win_o[cand] = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Round-robin owner of the shared I2C byte master: latches one requester's frame,
// feeds it byte by byte with a per-byte timeout, then pulses done/err.
module i2c_bus_scheduler
  import i2c_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int MAXB    = MAXB_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int LEN_W   = len_w(MAXB)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*LEN_W-1:0]  req_len_i,
  input  logic [NREQ*MAXB*8-1:0] req_data_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   m_start_o,
  output logic [7:0]             m_data_o,
  input  logic                   m_done_i
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_e      state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  win_idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [MAXB*8-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              err_q;
  logic              busy_q;
  logic              m_start_q;
  logic [7:0]        m_data_q;

  logic [NREQ-1:0]   win;
  logic              any_req;
  logic [PTR_W-1:0]  win_idx;
  logic [LEN_W-1:0]  idx_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              len_bad;
  logic              last_byte;
  logic              timed_out;

  i2c_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  assign idx_d     = (idx_q < LEN_W'(MAXB - 1)) ? idx_q + LEN_W'(1) : idx_q;
  assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign len_bad   = (len_q == '0) || (len_q > LEN_W'(MAXB));
  assign last_byte = ((idx_q + LEN_W'(1)) == len_q);
  // cnt_q counts completed WAIT cycles, so this is the TIMEOUT-th cycle without m_done.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_idx_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            // Frame is captured here once; later changes on the request lines are ignored.
            gnt_q     <= win;
            win_idx_q <= win_idx;
            busy_q    <= 1'b1;
            len_q     <= req_len_i[int'(win_idx)*LEN_W +: LEN_W];
            data_q    <= req_data_i[int'(win_idx)*MAXB*8 +: MAXB*8];
            idx_q     <= '0;
            state_q   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          ptr_q <= (win_idx_q == PTR_W'(NREQ - 1)) ? '0 : win_idx_q + PTR_W'(1);
          if (len_bad) begin
            gnt_q   <= '0;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            m_start_q <= 1'b1;
            m_data_q  <= data_q[int'(idx_q)*8 +: 8];
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          m_start_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (m_done_i) begin
            idx_q <= idx_d;
            if (last_byte) begin
              gnt_q   <= '0;
              done_q  <= gnt_q;
              state_q <= ST_FINISH;
            end else begin
              m_start_q <= 1'b1;
              m_data_q  <= data_q[int'(idx_d)*8 +: 8];
              state_q   <= ST_ISSUE;
            end
          end else if (timed_out) begin
            gnt_q   <= '0;
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_FINISH: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;
  assign m_start_o = m_start_q;
  assign m_data_o  = m_data_q;

endmodule
